// File: rtl/vp_encoder_sched_if.sv
// Encoder/PE-side bus of the VP encoder row scheduler.
// Signal names carry the scheduler's direction (o_ = driven by the scheduler).
interface vp_encoder_sched_if #(
  parameter int ROW_W = 8
);
  logic [ROW_W-1:0] o_row_idx;
  logic             o_enc_start;
  logic             i_enc_right_rdy;
  logic             i_enc_left_rdy;
  logic             i_enc_finish;
  logic             o_pe_valid;
  logic             o_pe_sel;
  logic             o_pe_last;
  logic             i_pe_ready;

  modport master (
    output o_row_idx, o_enc_start, o_pe_valid, o_pe_sel, o_pe_last,
    input  i_enc_right_rdy, i_enc_left_rdy, i_enc_finish, i_pe_ready
  );

  modport slave (
    input  o_row_idx, o_enc_start, o_pe_valid, o_pe_sel, o_pe_last,
    output i_enc_right_rdy, i_enc_left_rdy, i_enc_finish, i_pe_ready
  );
endinterface

// File: rtl/vp_encoder_sched.sv
// VP encoder row scheduler: row stepping, encoder start, buffer forwarding to the PE array.
// Optional perf counters (o_stall_cnt / o_xfer_cnt) are built when VPENC_SCHED_PERF_EN is defined.
module vp_encoder_sched #(
  parameter int ROW_W    = 8,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_start,
  input  logic [ROW_W-1:0]   i_num_rows,
  vp_encoder_sched_if.master bus,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err_overrun
`ifdef VPENC_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]   o_stall_cnt,
  output logic [CNT_W-1:0]   o_xfer_cnt
`endif
);

  localparam int LW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  if (LOAD_LAT < 1 || CNT_W < 1) begin : g_bad_param
    $error("vp_encoder_sched: LOAD_LAT and CNT_W must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t           r_state;
  logic [ROW_W-1:0] r_rows;
  logic [LW-1:0]    r_load_cnt;

  logic w_fwd, w_rdy, w_both, w_xfer, w_fin, w_empty, w_start;

  assign w_start = (r_state == S_IDLE) & i_cfg_start;
  assign w_fwd   = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign w_rdy   = bus.i_enc_right_rdy | bus.i_enc_left_rdy;
  assign w_both  = bus.i_enc_right_rdy & bus.i_enc_left_rdy;
  assign w_xfer  = bus.o_pe_valid & bus.i_pe_ready;
  assign w_fin   = (r_state == S_RUN) & bus.i_enc_finish;
  // Nothing left to hand over once the current offer is taken and no new buffer arrives.
  assign w_empty = (~bus.o_pe_valid | w_xfer) & ~w_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_rows          <= '0;
      r_load_cnt      <= '0;
      bus.o_row_idx   <= '0;
      bus.o_enc_start <= 1'b0;
      bus.o_pe_valid  <= 1'b0;
      bus.o_pe_sel    <= 1'b0;
      bus.o_pe_last   <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_err_overrun   <= 1'b0;
    end else begin
      bus.o_enc_start <= 1'b0;
      o_done          <= 1'b0;

      // A fresh ready pulse always wins: it either re-arms after a handshake
      // or overwrites an unaccepted buffer (overrun, old buffer dropped).
      if (w_fwd) begin
        if (w_rdy) begin
          bus.o_pe_valid <= 1'b1;
          bus.o_pe_sel   <= bus.i_enc_left_rdy;
          bus.o_pe_last  <= (r_state == S_DRAIN) | w_fin;
          if ((bus.o_pe_valid & ~bus.i_pe_ready) | w_both)
            o_err_overrun <= 1'b1;
        end else if (w_xfer) begin
          bus.o_pe_valid <= 1'b0;
          bus.o_pe_last  <= 1'b0;
        end else if (w_fin & bus.o_pe_valid) begin
          bus.o_pe_last  <= 1'b1;
        end
      end else begin
        bus.o_pe_valid <= 1'b0;
        bus.o_pe_last  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_cfg_start) begin
            r_rows        <= i_num_rows;
            o_err_overrun <= 1'b0;
            o_busy        <= 1'b1;
            if (i_num_rows == '0) begin
              r_state <= S_DONE;
            end else begin
              bus.o_row_idx <= '0;
              r_load_cnt    <= '0;
              r_state       <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (r_load_cnt == LW'(LOAD_LAT - 1)) begin
            bus.o_enc_start <= 1'b1;
            r_state         <= S_RUN;
          end else begin
            r_load_cnt <= r_load_cnt + LW'(1);
          end
        end
        S_RUN: begin
          if (bus.i_enc_finish) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_empty) begin
            if (bus.o_row_idx == r_rows - ROW_W'(1)) begin
              r_state <= S_DONE;
            end else begin
              bus.o_row_idx <= bus.o_row_idx + ROW_W'(1);
              r_load_cnt    <= '0;
              r_state       <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef VPENC_SCHED_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
      o_xfer_cnt  <= '0;
    end else if (w_start) begin
      o_stall_cnt <= '0;
      o_xfer_cnt  <= '0;
    end else begin
      if (bus.o_pe_valid & ~bus.i_pe_ready & (o_stall_cnt != '1))
        o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (w_xfer & (o_xfer_cnt != '1))
        o_xfer_cnt <= o_xfer_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
